// File: rtl/rom_dl_pkg.sv
// Shared types and helpers for the ioctl download router.
package rom_dl_pkg;

   localparam int unsigned DL_NUM_REGIONS = 17;
   localparam int unsigned DL_ADDR_W      = 25;
   localparam int unsigned RGN_IDX_W      = $clog2(DL_NUM_REGIONS);
   localparam int unsigned SZ_W           = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_DONE
   } state_t;

   // Low byte of a wide word waiting for its high partner.
   typedef struct packed {
      logic                 valid;
      logic [RGN_IDX_W-1:0] region;
      logic [31:0]          word;
      logic [7:0]           data;
   } pend_t;

   function automatic logic [31:0] rgn_mask(input logic [SZ_W-1:0] sz);
      return (32'd1 << sz) - 32'd1;
   endfunction

   // Range check comes first, so the subtraction can never wrap.
   function automatic logic rgn_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [SZ_W-1:0] sz);
      return (addr >= base) && ((addr - base) <= rgn_mask(sz));
   endfunction

endpackage

// File: rtl/rom_dl_if.sv
// ioctl byte stream in, per-region ROM write port and status out.
interface rom_dl_if #(
   parameter int unsigned NUM_REGIONS = 17,
   parameter int unsigned ADDR_W      = 25
);
   logic                   ioctl_download;
   logic [ADDR_W-1:0]      ioctl_addr;
   logic [7:0]             ioctl_data;
   logic                   ioctl_wr;
   logic [NUM_REGIONS-1:0] rgn_we;
   logic [ADDR_W-1:0]      rgn_addr;
   logic [15:0]            rgn_data;
   logic [1:0]             rgn_be;
   logic [NUM_REGIONS-1:0] rgn_done;
   logic                   unmapped_err;
   logic                   dl_busy;
   logic                   dl_done;

   modport master (
      output ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
      input  rgn_we, rgn_addr, rgn_data, rgn_be, rgn_done,
             unmapped_err, dl_busy, dl_done
   );

   modport slave (
      input  ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
      output rgn_we, rgn_addr, rgn_data, rgn_be, rgn_done,
             unmapped_err, dl_busy, dl_done
   );
endinterface

// File: rtl/rom_dl_decode.sv
// Priority address decoder: lowest-indexed matching region wins.
module rom_dl_decode
   import rom_dl_pkg::*;
#(
   parameter int unsigned NUM_REGIONS = DL_NUM_REGIONS,
   parameter int unsigned ADDR_W      = DL_ADDR_W,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE    = '0,
   parameter logic [NUM_REGIONS*SZ_W-1:0]   REGION_SZ_LOG2 = {NUM_REGIONS{5'd13}}
)(
   input  logic [ADDR_W-1:0]    addr,
   output logic                 hit_valid_c,
   output logic [RGN_IDX_W-1:0] hit_idx_c,
   output logic [ADDR_W-1:0]    offset_c
);

   // Scan from the top down so lower indices overwrite higher ones.
   always_comb begin
      hit_valid_c = 1'b0;
      hit_idx_c   = '0;
      offset_c    = '0;
      for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
         if (rgn_hit(32'(addr), 32'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                     REGION_SZ_LOG2[i*SZ_W +: SZ_W])) begin
            hit_valid_c = 1'b1;
            hit_idx_c   = RGN_IDX_W'(i);
            offset_c    = ADDR_W'((32'(addr) - 32'(REGION_BASE[i*ADDR_W +: ADDR_W]))
                                  & rgn_mask(REGION_SZ_LOG2[i*SZ_W +: SZ_W]));
         end
      end
   end

endmodule

// File: rtl/rom_dl_router.sv
// Routes the ioctl byte stream to narrow (byte) or wide (paired 16-bit) ROM regions.
module rom_dl_router
   import rom_dl_pkg::*;
#(
   parameter int unsigned NUM_REGIONS = DL_NUM_REGIONS,
   parameter int unsigned ADDR_W      = DL_ADDR_W,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE    = '0,
   parameter logic [NUM_REGIONS*SZ_W-1:0]   REGION_SZ_LOG2 = {NUM_REGIONS{5'd13}},
   parameter logic [NUM_REGIONS-1:0]        WIDE_MASK      = '0
)(
   input logic     clk_49m,
   input logic     reset,
   rom_dl_if.slave bus
);

   state_t                 state;
   pend_t                  pend;
   logic                   dl_q;
   logic                   dl_rise_c, dl_fall_c;
   logic                   hit_valid_c;
   logic [RGN_IDX_W-1:0]   hit_idx_c;
   logic [ADDR_W-1:0]      offset_c, word_c;
   logic [SZ_W-1:0]        hit_sz_c;
   logic                   hit_wide_c, hit_last_c, pend_match_c;
   logic [NUM_REGIONS-1:0] hit_hot_c, pend_hot_c;

   rom_dl_decode #(
      .NUM_REGIONS    (NUM_REGIONS),
      .ADDR_W         (ADDR_W),
      .REGION_BASE    (REGION_BASE),
      .REGION_SZ_LOG2 (REGION_SZ_LOG2)
   ) u_decode (
      .addr        (bus.ioctl_addr),
      .hit_valid_c (hit_valid_c),
      .hit_idx_c   (hit_idx_c),
      .offset_c    (offset_c)
   );

   assign dl_rise_c    = bus.ioctl_download & ~dl_q;
   assign dl_fall_c    = ~bus.ioctl_download & dl_q;
   assign hit_sz_c     = REGION_SZ_LOG2[32'(hit_idx_c)*SZ_W +: SZ_W];
   assign hit_wide_c   = WIDE_MASK[hit_idx_c];
   assign hit_last_c   = (32'(offset_c) == rgn_mask(hit_sz_c));
   assign word_c       = offset_c >> 1;
   assign hit_hot_c    = NUM_REGIONS'(1) << hit_idx_c;
   assign pend_hot_c   = NUM_REGIONS'(1) << pend.region;
   assign pend_match_c = pend.valid && (pend.region == hit_idx_c) && (pend.word == 32'(word_c));

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         state            <= ST_IDLE;
         pend             <= '0;
         dl_q             <= 1'b0;
         bus.rgn_we       <= '0;
         bus.rgn_addr     <= '0;
         bus.rgn_data     <= '0;
         bus.rgn_be       <= '0;
         bus.rgn_done     <= '0;
         bus.unmapped_err <= 1'b0;
         bus.dl_busy      <= 1'b0;
         bus.dl_done      <= 1'b0;
      end else begin
         dl_q        <= bus.ioctl_download;
         bus.rgn_we  <= '0;
         bus.dl_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (dl_rise_c) begin
                  state            <= ST_LOAD;
                  bus.dl_busy      <= 1'b1;
                  bus.rgn_done     <= '0;
                  bus.unmapped_err <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (dl_fall_c) state <= ST_FLUSH;
               if (bus.ioctl_wr) begin
                  if (!hit_valid_c) begin
                     bus.unmapped_err <= 1'b1;
                  end else begin
                     if (hit_last_c) bus.rgn_done <= bus.rgn_done | hit_hot_c;
                     if (!hit_wide_c) begin
                        bus.rgn_we   <= hit_hot_c;
                        bus.rgn_addr <= offset_c;
                        bus.rgn_data <= {8'h00, bus.ioctl_data};
                        bus.rgn_be   <= 2'b01;
                     end else if (!offset_c[0]) begin
                        // An unpaired low byte is written alone before being replaced.
                        if (pend.valid) begin
                           bus.rgn_we   <= pend_hot_c;
                           bus.rgn_addr <= ADDR_W'(pend.word);
                           bus.rgn_data <= {8'h00, pend.data};
                           bus.rgn_be   <= 2'b01;
                        end
                        pend <= '{valid: 1'b1, region: hit_idx_c,
                                  word: 32'(word_c), data: bus.ioctl_data};
                     end else begin
                        // A high byte without its matching low byte drops the stale one.
                        bus.rgn_we   <= hit_hot_c;
                        bus.rgn_addr <= word_c;
                        bus.rgn_data <= {bus.ioctl_data, pend_match_c ? pend.data : 8'h00};
                        bus.rgn_be   <= pend_match_c ? 2'b11 : 2'b10;
                        pend.valid   <= 1'b0;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               if (pend.valid) begin
                  bus.rgn_we   <= pend_hot_c;
                  bus.rgn_addr <= ADDR_W'(pend.word);
                  bus.rgn_data <= {8'h00, pend.data};
                  bus.rgn_be   <= 2'b01;
               end
               pend.valid  <= 1'b0;
               bus.dl_done <= 1'b1;
               state       <= ST_DONE;
            end
            ST_DONE: begin
               bus.dl_busy <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
